// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue sitting between the PC register and ID.
// Issues pc_i to a fixed-latency imem every cycle that there is credit,
// tracks in-flight requests in a valid shift register, and buffers the
// returned {pc, instr} pairs in a small FIFO whose head feeds ID.
// fetch_hold_o tells the PC register to hold when no credit is left.
module if_fetch_queue #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned IMEM_LAT = 1,
   parameter logic [31:0] RESET_PC = 32'hFFFF_FFFC,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic [31:0] imem_addr_o,
   output logic        imem_req_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        id_ready_i,
   input  logic        flush_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o,
   output logic        fetch_hold_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   // in-flight pipe: stage 0 is the request just issued, stage IMEM_LAT-1 is
   // the one whose instruction is on imem_rdata_i this cycle
   logic [IMEM_LAT-1:0]       vld_pipe;
   logic [IMEM_LAT-1:0][31:0] pc_pipe;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [31:0]     inflight;
   logic [31:0]     credit;
   logic            push, pop;
   entry_t          head;

   // count of requests still owed a queue slot
   always_comb begin
      inflight = '0;
      for (int i = 0; i < IMEM_LAT; i++)
         inflight = inflight + 32'(vld_pipe[i]);
   end

   // credit: every queued or in-flight entry owns a slot; a pop this cycle
   // frees one, so hold only when a new request would overrun the queue
   always_comb begin
      pop          = id_valid_o & id_ready_i & ~flush_i;
      credit       = 32'(count) + inflight - 32'(pop);
      fetch_hold_o = rst & (credit >= DEPTH);
      imem_req_o   = rst & ~flush_i & ~fetch_hold_o & (pc_i != RESET_PC);
      push         = vld_pipe[IMEM_LAT-1] & ~flush_i;
   end

   assign imem_addr_o = pc_i;

   // in-flight valid shift register; reset and flush kill every stage
   always_ff @(posedge clk) begin
      if (!rst || flush_i) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= imem_req_o;
         for (int i = 1; i < IMEM_LAT; i++)
            vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // in-flight PCs travel alongside their valid bits; no reset needed
   always_ff @(posedge clk) begin
      pc_pipe[0] <= pc_i;
      for (int i = 1; i < IMEM_LAT; i++)
         pc_pipe[i] <= pc_pipe[i-1];
   end

   // queue storage, written at the tail on push
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{pc: pc_pipe[IMEM_LAT-1], instr: imem_rdata_i};
   end

   // pointers and occupancy; flush behaves exactly like reset here
   always_ff @(posedge clk) begin
      if (!rst || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // credit accounting must make a push into a full queue impossible
   always_ff @(posedge clk) begin
      if (rst)
         assert (!(push && !pop && count == CW'(DEPTH)));
   end

   // head presented straight from queue registers; NOP/0 when empty
   always_comb begin
      head       = mem[rd_ptr];
      id_valid_o = (count != '0);
      id_pc_o    = id_valid_o ? head.pc    : 32'h0;
      id_instr_o = id_valid_o ? head.instr : NOP;
   end

endmodule
